mux8_serializer_ctrl: RTL and testbench
=======================================

# mux8_serializer_ctrl

Sequencing stage that sits directly upstream of the 8:1 multiplexer (`mux8x1`) and drives its `S` and `D` inputs. It accepts an 8-bit word through a valid/ready handshake and holds it on `D`. It then steps `S` through all eight bit indices, holding each index for a programmable number of clock cycles, so that the mux output `Y` becomes a timed serial bitstream. It also produces per-bit qualifiers and a completion pulse for the downstream consumer of `Y`.

## Interface
Parameters:
- `DIV`, default 4: clock cycles each bit index is held; legal range 1..256.
- `MSB_FIRST`, default 0: 0 steps `S` 0→7; 1 steps `S` 7→0.

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `load_valid`  input  1  upstream presents a word.
- `load_data`  input  8  word to serialize; sampled only on handshake.
- `load_ready`  output  1  block can accept a word.
- `S`  output  3  select for the mux.
- `D`  output  8  held word for the mux.
- `bit_valid`  output  1  `S`/`D` currently present a live bit.
- `last`  output  1  live bit is the final (8th) bit of the word.
- `done`  output  1  one-cycle pulse after the final bit period ends.

## Operation
- Two states: `IDLE` and `SHIFT`. All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Reset values:
  - State = `IDLE`.
  - `D` = 0x00.
  - `S` = 0 if `MSB_FIRST`=0, else 7.
  - `load_ready` = 1; `bit_valid` = 0; `last` = 0; `done` = 0.
- Internal counters:
  - `div_cnt`: width ceil(log2(DIV)), minimum 1 bit.
  - `bit_cnt`: 3 bits, 0..7.
- `IDLE` state:
  - `load_ready`=1, `bit_valid`=0.
  - `D` holds the previous word; `S` holds the first index.
  - On an edge with `load_valid`&&`load_ready`: `D`←`load_data`, `S`←first index, `div_cnt`←0, `bit_cnt`←0, go to `SHIFT`.
- `SHIFT` state:
  - `load_ready`=0, `bit_valid`=1.
  - Each edge, `div_cnt` increments.
  - When `div_cnt`==DIV-1: `div_cnt`←0.
    - If `bit_cnt`==7: go to `IDLE`, `S`←first index, `done`←1.
    - Otherwise: `bit_cnt`←`bit_cnt`+1, and `S`←`S`+1 (LSB-first) or `S`−1 (MSB-first). `S` never wraps during a word.
- `last` = `bit_valid` && (`bit_cnt`==7).
- `done` is high for exactly one cycle: the first `IDLE` cycle after a completed word.
- `load_valid` while in `SHIFT` is ignored. The word is not captured; upstream must hold it until `load_ready`.
- `D` is stable for the whole of `SHIFT`; `load_data` changes have no effect.
- If `rst` asserts mid-word, all registers return to reset values immediately and asynchronously. The partial word is discarded and no `done` pulse is issued.
- DIV=1: `S` advances every cycle and `div_cnt` is a constant-zero 1-bit register.

## Timing
- Let edge k be the handshake edge.
- Bit i (i=0..7) is presented on `S` during cycles k+1+i·DIV through k+(i+1)·DIV, with `bit_valid`=1 throughout.
- The final bit ends at edge k+8·DIV. `done`=1 and `load_ready`=1 in the cycle that follows.
- A new word can be accepted on the same edge that ends the `done` cycle. Minimum word period is therefore 8·DIV+1 cycles.
- `Y` latency equals the mux combinational delay after each `S` update; this block adds no extra register stage.

## Test plan
- **Reset:** assert `rst` mid-cycle with no clock → all outputs take their reset values immediately: `load_ready`=1, `S`=0, `D`=0x00, `bit_valid`=`last`=`done`=0.
- **Single word, LSB-first, DIV=4:** load 0xA5 → `S` steps 0,1,…,7 holding each for 4 cycles. Mux `Y` reads 1,0,1,0,0,1,0,1. `last` is high for the final 4 cycles. `done` is high for exactly cycle k+33.
- **MSB-first, DIV=1:** load 0x3C → `S` steps 7,6,…,0 on consecutive cycles. `Y` reads 0,0,1,1,1,1,0,0. `done` is high at cycle k+9.
- **Back-to-back with `load_valid` held high:** words 0xFF then 0x00 → second handshake occurs exactly at the end of the `done` cycle. 0xFF is never overwritten mid-word. Word period is 33 cycles.
- **Busy rejection:** during `SHIFT` of 0x81, pulse `load_valid` with 0x7E → `D` stays 0x81 and the bitstream is unchanged.
- **Reset mid-word:** load 0xF0 and assert `rst` at bit 3 → immediate return to reset values with no `done` pulse. A new load of 0x0F after release serializes correctly from bit 0.

Source files
------------

// File: rtl/mux8_serializer_ctrl.sv
// mux8_serializer_ctrl: loads a byte over valid/ready and steps the 8:1 mux
// select through all bit indices, holding each for DIV clock cycles.
module mux8_serializer_ctrl #(
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic [2:0] S,
    output logic [7:0] D,
    output logic       bit_valid,
    output logic       last,
    output logic       done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_END = CW'(DIV - 1);
    localparam logic [2:0] FIRST = (MSB_FIRST != 0) ? 3'd7 : 3'd0;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] div_cnt, div_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [2:0]    s_n;
    logic [7:0]    d_n;
    logic          done_n;

    // State and datapath registers; the partial word is discarded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            S       <= FIRST;
            D       <= 8'h00;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
            bit_cnt <= bit_cnt_n;
            S       <= s_n;
            D       <= d_n;
            done    <= done_n;
        end
    end

    // Next-state logic: capture on handshake, then pace bits by div_cnt.
    always_comb begin
        state_n   = state;
        div_cnt_n = div_cnt;
        bit_cnt_n = bit_cnt;
        s_n       = S;
        d_n       = D;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_valid) begin
                    d_n       = load_data;
                    s_n       = FIRST;
                    div_cnt_n = '0;
                    bit_cnt_n = 3'd0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_END) begin
                    div_cnt_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = IDLE;
                        s_n     = FIRST;
                        done_n  = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        s_n = (MSB_FIRST != 0) ? S - 3'd1 : S + 3'd1;
                    end
                end else begin
                    div_cnt_n = div_cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign load_ready = (state == IDLE);
    assign bit_valid  = (state == SHIFT);
    assign last       = bit_valid && (bit_cnt == 3'd7);

endmodule

// File: tb/tb_mux8_serializer_ctrl.sv
// Bench for mux8_serializer_ctrl: one LSB-first DIV=4 instance and one
// MSB-first DIV=1 instance, checked by directed tables and a timing model.
module tb_mux8_serializer_ctrl;

    logic clk;
    logic rst;
    logic [1:0]      lv;
    logic [1:0][7:0] ld;
    logic [1:0]      lr;
    logic [1:0][2:0] ss;
    logic [1:0][7:0] dd;
    logic [1:0]      bv;
    logic [1:0]      la;
    logic [1:0]      dn;

    int total = 0;
    int bad   = 0;
    logic sb_en = 1'b0;

    mux8_serializer_ctrl #(.DIV(4), .MSB_FIRST(0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv[0]),
        .load_data  (ld[0]),
        .load_ready (lr[0]),
        .S          (ss[0]),
        .D          (dd[0]),
        .bit_valid  (bv[0]),
        .last       (la[0]),
        .done       (dn[0])
    );

    mux8_serializer_ctrl #(.DIV(1), .MSB_FIRST(1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv[1]),
        .load_data  (ld[1]),
        .load_ready (lr[1]),
        .S          (ss[1]),
        .D          (dd[1]),
        .bit_valid  (bv[1]),
        .last       (la[1]),
        .done       (dn[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int div_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int msb_of(int i);
        return (i == 0) ? 0 : 1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a word occupies 8*DIV cycles counted from the
    // handshake; bit index is elapsed/DIV, mapped by the bit order.
    int         mt[2];
    logic       mbusy[2];
    logic [7:0] mword[2];
    logic       mdone[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mt[i]    <= 0;
                mbusy[i] <= 1'b0;
                mword[i] <= 8'h00;
                mdone[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                mdone[i] <= mbusy[i] && (mt[i] == 8 * div_of(i) - 1);
                if (mbusy[i]) begin
                    if (mt[i] == 8 * div_of(i) - 1) mbusy[i] <= 1'b0;
                    else mt[i] <= mt[i] + 1;
                end else if (lv[i]) begin
                    mbusy[i] <= 1'b1;
                    mt[i]    <= 0;
                    mword[i] <= ld[i];
                end
            end
        end
    end

    function automatic logic [2:0] exp_s(int i);
        int b;
        if (!mbusy[i]) return (msb_of(i) != 0) ? 3'd7 : 3'd0;
        b = mt[i] / div_of(i);
        return 3'((msb_of(i) != 0) ? 7 - b : b);
    endfunction

    always @(negedge clk) begin
        if (sb_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("sb%0d_ready", i), 32'(lr[i]), 32'(!mbusy[i]));
                chk($sformatf("sb%0d_valid", i), 32'(bv[i]), 32'(mbusy[i]));
                chk($sformatf("sb%0d_S", i), 32'(ss[i]), 32'(exp_s(i)));
                chk($sformatf("sb%0d_D", i), 32'(dd[i]), 32'(mword[i]));
                chk($sformatf("sb%0d_last", i), 32'(la[i]),
                    32'(mbusy[i] && (mt[i] / div_of(i) == 7)));
                chk($sformatf("sb%0d_done", i), 32'(dn[i]), 32'(mdone[i]));
            end
        end
    end

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic [7:0] yseq;
    } vec_t;

    vec_t tbl[4];

    task automatic wait_ready(int i);
        for (int n = 0; n < 200; n++) begin
            if (lr[i]) return;
            @(negedge clk);
        end
        chk($sformatf("wait_ready%0d", i), 32'd0, 32'd1);
    endtask

    task automatic run_word(int i, logic [7:0] data, logic [7:0] yseq,
                            bit inject);
        int dv;
        logic y;
        dv = div_of(i);
        wait_ready(i);
        ld[i] = data;
        lv[i] = 1'b1;
        @(negedge clk);
        lv[i] = 1'b0;
        for (int c = 0; c < 8 * dv; c++) begin
            if (c > 0) @(negedge clk);
            if (inject && c == 5) begin
                lv[i] = 1'b1;
                ld[i] = ~data;
            end
            if (inject && c == 6) lv[i] = 1'b0;
            if (c % dv == 0) begin
                y = dd[i][ss[i]];
                chk($sformatf("y%0d_bit%0d", i, c / dv), 32'(y),
                    32'(yseq[c / dv]));
                chk("word_D", 32'(dd[i]), 32'(data));
                chk("last", 32'(la[i]), 32'(c / dv == 7));
                chk("bit_valid", 32'(bv[i]), 32'd1);
            end
        end
        @(negedge clk);
        chk("done_hi", 32'(dn[i]), 32'd1);
        chk("done_ready", 32'(lr[i]), 32'd1);
        @(negedge clk);
        chk("done_lo", 32'(dn[i]), 32'd0);
    endtask

    task automatic check_reset_vals();
        chk("rst_ready0", 32'(lr[0]), 32'd1);
        chk("rst_S0", 32'(ss[0]), 32'd0);
        chk("rst_D0", 32'(dd[0]), 32'h00);
        chk("rst_bv0", 32'(bv[0]), 32'd0);
        chk("rst_last0", 32'(la[0]), 32'd0);
        chk("rst_done0", 32'(dn[0]), 32'd0);
        chk("rst_S1", 32'(ss[1]), 32'd7);
        chk("rst_ready1", 32'(lr[1]), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        lv  = '0;
        ld  = '0;
        tbl[0] = '{inst: 0, data: 8'hA5, yseq: 8'hA5};
        tbl[1] = '{inst: 1, data: 8'h3C, yseq: 8'h3C};
        tbl[2] = '{inst: 1, data: 8'h4B, yseq: 8'hD2};
        tbl[3] = '{inst: 0, data: 8'h4B, yseq: 8'h4B};

        #3 rst = 1'b1;
        #1 check_reset_vals();
        sb_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[k]) run_word(tbl[k].inst, tbl[k].data, tbl[k].yseq, 1'b0);

        // Back-to-back with load_valid held: period must be 33 cycles.
        wait_ready(0);
        ld[0] = 8'hFF;
        lv[0] = 1'b1;
        @(negedge clk);
        ld[0] = 8'h00;
        chk("b2b_busy", 32'(lr[0]), 32'd0);
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (n == 16) chk("b2b_hold", 32'(dd[0]), 32'hFF);
            if (lr[0]) break;
        end
        chk("b2b_period", 32'(n), 32'd33);
        chk("b2b_done", 32'(dn[0]), 32'd1);
        @(negedge clk);
        lv[0] = 1'b0;
        chk("b2b_second", 32'(dd[0]), 32'h00);
        chk("b2b_second_busy", 32'(lr[0]), 32'd0);
        wait_ready(0);
        @(negedge clk);

        // Busy rejection: a pulse during SHIFT must not disturb the word.
        run_word(0, 8'h81, 8'h81, 1'b1);

        // Reset mid-word: no done, then a clean word afterwards.
        wait_ready(0);
        ld[0] = 8'hF0;
        lv[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        n = 0;
        while (ss[0] != 3'd3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit3", 32'(ss[0]), 32'd3);
        #1 rst = 1'b1;
        #1 check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'(dn[0]), 32'd0);
        end
        run_word(0, 8'h0F, 8'h0F, 1'b0);

        // Random traffic on both instances against the model.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                lv[i] = ($urandom_range(0, 2) == 0);
                ld[i] = 8'($urandom);
            end
            if (c == 400) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        lv = '0;
        sb_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
